// File: rtl/ex_md_pkg.sv
// Shared types and helpers for the EX stage with its iterative multiply/divide unit.
package ex_md_pkg;

  // Decoded operation presented by ID/EX.
  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUBU  = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_NOR   = 5'd6,
    OP_SLT   = 5'd7,
    OP_SLTU  = 5'd8,
    OP_SLL   = 5'd9,
    OP_SRL   = 5'd10,
    OP_SRA   = 5'd11,
    OP_LUI   = 5'd12,
    OP_MULT  = 5'd13,
    OP_MULTU = 5'd14,
    OP_DIV   = 5'd15,
    OP_DIVU  = 5'd16,
    OP_MFHI  = 5'd17,
    OP_MFLO  = 5'd18,
    OP_MTHI  = 5'd19,
    OP_MTLO  = 5'd20
  } op_t;

  localparam int DEF_MUL_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

  // Operations that launch a multiply/divide.
  function automatic logic is_md_start(input op_t op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Operations that touch HI/LO and therefore must wait for an in-flight multiply/divide.
  function automatic logic is_hilo_use(input op_t op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  // Operations that never produce a GPR result, whatever the decoder said.
  function automatic logic writes_gpr(input op_t op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MTHI, OP_MTLO: r = 1'b0;
      default:          r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_md_if.sv
// ID/EX -> EX -> EX/MEM signal bundle; master is the pipeline side, slave is the stage.
interface ex_md_if #(
  parameter int DW = 32
);
  import ex_md_pkg::*;

  logic          valid_in;
  op_t           op_in;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] imm_ext;
  logic          use_imm;
  logic [4:0]    shamt;
  logic [4:0]    wa_in;
  logic          we_in;
  logic          stall_req;
  logic          md_busy;
  logic          valid_out;
  logic [DW-1:0] alu_out;
  logic [DW-1:0] dm_wdata;
  logic [4:0]    wa_out;
  logic          we_out;

  modport master (
    output valid_in, op_in, rs_data, rt_data, imm_ext, use_imm, shamt, wa_in, we_in,
    input  stall_req, md_busy, valid_out, alu_out, dm_wdata, wa_out, we_out
  );

  modport slave (
    input  valid_in, op_in, rs_data, rt_data, imm_ext, use_imm, shamt, wa_in, we_in,
    output stall_req, md_busy, valid_out, alu_out, dm_wdata, wa_out, we_out
  );

endinterface

// File: rtl/ex_md_stage_md_unit.sv
// Iterative multiply/divide unit: latches operands at start, counts down the
// configured latency and commits the combinational result to HI/LO on the last count.
module md_unit
  import ex_md_pkg::*;
#(
  parameter int DW         = 32,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  op_t           op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          mthi_i,
  input  logic          mtlo_i,
  input  logic [DW-1:0] mt_data_i,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          busy_o
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  op_t             op_q, op_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic            sgn_op_s, mul_op_s, a_neg_s, b_neg_s;
  logic [2*DW-1:0] prod_s;
  logic [DW-1:0]   a_mag_s, b_mag_s, uq_s, ur_s, quot_s, rem_s;

  // Multiply and divide results from the latched operands (signed divide truncates toward zero).
  always_comb begin
    sgn_op_s = (op_q == OP_MULT) || (op_q == OP_DIV);
    mul_op_s = (op_q == OP_MULT) || (op_q == OP_MULTU);
    a_neg_s  = sgn_op_s & a_q[DW-1];
    b_neg_s  = sgn_op_s & b_q[DW-1];
    if (sgn_op_s) begin
      prod_s = {{DW{a_q[DW-1]}}, a_q} * {{DW{b_q[DW-1]}}, b_q};
    end else begin
      prod_s = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
    end
    a_mag_s = a_neg_s ? ('0 - a_q) : a_q;
    b_mag_s = b_neg_s ? ('0 - b_q) : b_q;
    uq_s    = '0;
    ur_s    = '0;
    if (b_q == '0) begin
      // Divide by zero: all-ones quotient, dividend kept as remainder.
      quot_s = '1;
      rem_s  = a_q;
    end else begin
      // Most-negative / -1 falls out naturally: magnitude quotient negates back to itself.
      uq_s   = a_mag_s / b_mag_s;
      ur_s   = a_mag_s % b_mag_s;
      quot_s = (a_neg_s ^ b_neg_s) ? ('0 - uq_s) : uq_s;
      rem_s  = a_neg_s ? ('0 - ur_s) : ur_s;
    end
  end

  // Next state: start loads the counter, last count commits HI/LO, idle allows MTHI/MTLO.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start_i) begin
      cnt_d  = ((op_i == OP_MULT) || (op_i == OP_MULTU)) ? MUL_LOAD : DIV_LOAD;
      busy_d = 1'b1;
      op_d   = op_i;
      a_d    = a_i;
      b_d    = b_i;
    end else if (cnt_q == CNT_ONE) begin
      cnt_d  = '0;
      busy_d = 1'b0;
      if (mul_op_s) begin
        hi_d = prod_s[2*DW-1:DW];
        lo_d = prod_s[DW-1:0];
      end else begin
        hi_d = rem_s;
        lo_d = quot_s;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      if (mthi_i) begin
        hi_d = mt_data_i;
      end else begin
        hi_d = hi_q;
      end
      if (mtlo_i) begin
        lo_d = mt_data_i;
      end else begin
        lo_d = lo_q;
      end
    end
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      op_q   <= OP_NOP;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/ex_md_stage.sv
// Pipelined EX stage: ALU, multiply/divide unit, HI/LO hazard stall and EX/MEM register.
module ex_md_stage
  import ex_md_pkg::*;
#(
  parameter int DW         = 32,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
  input  logic    clk,
  input  logic    reset,
  ex_md_if.slave  bus
);

  logic [DW-1:0] hi_s, lo_s;
  logic          md_busy_s, stall_s, accept_s, md_start_s, mthi_s, mtlo_s;
  logic [DW-1:0] opb_s, alu_s;

  logic          valid_q, valid_d, we_q, we_d;
  logic [DW-1:0] alu_q, alu_d, wdata_q, wdata_d;
  logic [4:0]    wa_q, wa_d;

  // Only HI/LO users wait on the multiply/divide; everything else flows through.
  assign stall_s    = bus.valid_in & md_busy_s & is_hilo_use(bus.op_in);
  assign accept_s   = bus.valid_in & ~stall_s;
  assign md_start_s = accept_s & is_md_start(bus.op_in);
  assign mthi_s     = accept_s & (bus.op_in == OP_MTHI);
  assign mtlo_s     = accept_s & (bus.op_in == OP_MTLO);

  md_unit #(
    .DW         (DW),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk       (clk),
    .rst_n     (reset),
    .start_i   (md_start_s),
    .op_i      (bus.op_in),
    .a_i       (bus.rs_data),
    .b_i       (bus.rt_data),
    .mthi_i    (mthi_s),
    .mtlo_i    (mtlo_s),
    .mt_data_i (bus.rs_data),
    .hi_o      (hi_s),
    .lo_o      (lo_s),
    .busy_o    (md_busy_s)
  );

  // ALU result; shifts act on rt, arithmetic wraps without trapping.
  always_comb begin
    opb_s = bus.use_imm ? bus.imm_ext : bus.rt_data;
    alu_s = '0;
    case (bus.op_in)
      OP_ADDU: alu_s = bus.rs_data + opb_s;
      OP_SUBU: alu_s = bus.rs_data - opb_s;
      OP_AND:  alu_s = bus.rs_data & opb_s;
      OP_OR:   alu_s = bus.rs_data | opb_s;
      OP_XOR:  alu_s = bus.rs_data ^ opb_s;
      OP_NOR:  alu_s = ~(bus.rs_data | opb_s);
      OP_SLT:  alu_s = {{(DW-1){1'b0}}, ($signed(bus.rs_data) < $signed(opb_s))};
      OP_SLTU: alu_s = {{(DW-1){1'b0}}, (bus.rs_data < opb_s)};
      OP_SLL:  alu_s = bus.rt_data << bus.shamt;
      OP_SRL:  alu_s = bus.rt_data >> bus.shamt;
      OP_SRA:  alu_s = $signed(bus.rt_data) >>> bus.shamt;
      OP_LUI:  alu_s = bus.imm_ext << 5'd16;
      OP_MFHI: alu_s = hi_s;
      OP_MFLO: alu_s = lo_s;
      default: alu_s = '0;
    endcase
  end

  // EX/MEM next value: accepted instruction or an all-zero bubble.
  always_comb begin
    valid_d = 1'b0;
    we_d    = 1'b0;
    alu_d   = '0;
    wdata_d = '0;
    wa_d    = 5'd0;
    if (accept_s) begin
      valid_d = 1'b1;
      we_d    = bus.we_in & writes_gpr(bus.op_in);
      alu_d   = alu_s;
      wdata_d = bus.rt_data;
      wa_d    = bus.wa_in;
    end else begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      alu_d   = '0;
      wdata_d = '0;
      wa_d    = 5'd0;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      alu_q   <= '0;
      wdata_q <= '0;
      wa_q    <= 5'd0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      wa_q    <= wa_d;
    end
  end

  assign bus.stall_req = stall_s;
  assign bus.md_busy   = md_busy_s;
  assign bus.valid_out = valid_q;
  assign bus.we_out    = we_q;
  assign bus.alu_out   = alu_q;
  assign bus.dm_wdata  = wdata_q;
  assign bus.wa_out    = wa_q;

endmodule

// File: tb/tb_ex_md_stage.sv
// Directed self-checking bench for ex_md_stage (DW=32, MUL_CYCLES=5, DIV_CYCLES=10).
module tb_ex_md_stage;
  import ex_md_pkg::*;

  localparam int DW   = 32;
  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  ex_md_if #(.DW(DW)) bus ();

  ex_md_stage #(
    .DW         (DW),
    .MUL_CYCLES (MULC),
    .DIV_CYCLES (DIVC)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input op_t op, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                       input logic [DW-1:0] imm, input logic ui, input logic [4:0] sh);
    bus.valid_in = 1'b1;
    bus.op_in    = op;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    bus.imm_ext  = imm;
    bus.use_imm  = ui;
    bus.shamt    = sh;
    bus.wa_in    = 5'd9;
    bus.we_in    = 1'b1;
  endtask

  task automatic idle();
    bus.valid_in = 1'b0;
    bus.op_in    = OP_NOP;
    bus.rs_data  = 32'h0;
    bus.rt_data  = 32'h0;
    bus.imm_ext  = 32'h0;
    bus.use_imm  = 1'b0;
    bus.shamt    = 5'd0;
    bus.wa_in    = 5'd0;
    bus.we_in    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_vec(input string tag, input op_t op, input logic [DW-1:0] rs,
                         input logic [DW-1:0] rt, input logic [DW-1:0] imm, input logic ui,
                         input logic [4:0] sh, input logic [DW-1:0] exp);
    drive(op, rs, rt, imm, ui, sh);
    #1;
    check({tag, "_stall"}, bus.stall_req, 64'd0);
    tick();
    check(tag, bus.alu_out, exp);
    check({tag, "_valid"}, bus.valid_out, 64'd1);
    check({tag, "_we"}, bus.we_out, 64'd1);
    check({tag, "_wa"}, bus.wa_out, 64'd9);
    check({tag, "_wdata"}, bus.dm_wdata, rt);
  endtask

  task automatic read_hilo(input string tag, input op_t op, input logic [DW-1:0] exp);
    drive(op, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    #1;
    check({tag, "_stall"}, bus.stall_req, 64'd0);
    tick();
    check(tag, bus.alu_out, exp);
  endtask

  // Start an MD op, put MFLO right behind it, count the stall, then read LO and HI.
  task automatic md_run(input string tag, input op_t op, input logic [DW-1:0] rs,
                        input logic [DW-1:0] rt, input int ncyc,
                        input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo);
    int n;
    drive(op, rs, rt, 32'h0, 1'b0, 5'd0);
    #1;
    check({tag, "_start_stall"}, bus.stall_req, 64'd0);
    tick();
    check({tag, "_issue_valid"}, bus.valid_out, 64'd1);
    check({tag, "_issue_we"}, bus.we_out, 64'd0);
    check({tag, "_busy"}, bus.md_busy, 64'd1);
    drive(OP_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    #1;
    n = 0;
    while (bus.stall_req && n < 50) begin
      tick();
      check({tag, "_bubble"}, bus.valid_out, 64'd0);
      n++;
    end
    check({tag, "_stall_cycles"}, 64'(n), 64'(ncyc));
    tick();
    check({tag, "_lo"}, bus.alu_out, exp_lo);
    read_hilo({tag, "_hi"}, OP_MFHI, exp_hi);
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_valid", bus.valid_out, 64'd0);
    check("rst_alu", bus.alu_out, 64'd0);
    check("rst_busy", bus.md_busy, 64'd0);
    rst_n = 1'b1;

    // ALU vectors
    alu_vec("addu_wrap", OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 32'h0, 1'b0, 5'd0, 32'h80000000);
    alu_vec("slt_neg",   OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0, 5'd0, 32'h00000001);
    alu_vec("sltu_neg",  OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1'b0, 5'd0, 32'h00000000);
    alu_vec("sra",       OP_SRA,  32'h0, 32'h80000000, 32'h0, 1'b0, 5'd4, 32'hF8000000);
    alu_vec("srl",       OP_SRL,  32'h0, 32'h80000000, 32'h0, 1'b0, 5'd4, 32'h08000000);
    alu_vec("sll",       OP_SLL,  32'h0, 32'h00000003, 32'h0, 1'b0, 5'd31, 32'h80000000);
    alu_vec("subu",      OP_SUBU, 32'h00000000, 32'h00000001, 32'h0, 1'b0, 5'd0, 32'hFFFFFFFF);
    alu_vec("nor",       OP_NOR,  32'h0F0F0000, 32'h00000F0F, 32'h0, 1'b0, 5'd0, 32'hF0F0F0F0);
    alu_vec("lui",       OP_LUI,  32'h0, 32'h00000055, 32'h00001234, 1'b1, 5'd0, 32'h12340000);
    alu_vec("addiu",     OP_ADDU, 32'h00000010, 32'h00000055, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h0000000F);
    idle();
    tick();
    check("idle_bubble", bus.valid_out, 64'd0);

    // Multiply / divide with HI/LO hazard
    md_run("mult",  OP_MULT,  32'hFFFFFFFD, 32'h00000007, MULC, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md_run("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MULC, 32'hFFFFFFFE, 32'h00000001);
    md_run("div",   OP_DIV,   32'hFFFFFFF9, 32'h00000002, DIVC, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_run("divu0", OP_DIVU,  32'h00000007, 32'h00000000, DIVC, 32'h00000007, 32'hFFFFFFFF);
    md_run("divmin", OP_DIV,  32'h80000000, 32'hFFFFFFFF, DIVC, 32'h00000000, 32'h80000000);

    // MTHI/MTLO round trip
    drive(OP_MTLO, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    check("mtlo_we", bus.we_out, 64'd0);
    drive(OP_MTHI, 32'h5A5A5A5A, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    read_hilo("mtlo_rd", OP_MFLO, 32'hA5A5A5A5);
    read_hilo("mthi_rd", OP_MFHI, 32'h5A5A5A5A);

    // DIV followed by independent ALU ops: no stall
    drive(OP_DIV, 32'd100, 32'd7, 32'h0, 1'b0, 5'd0);
    tick();
    check("div_alu_busy", bus.md_busy, 64'd1);
    alu_vec("div_add1", OP_ADDU, 32'd5, 32'd6, 32'h0, 1'b0, 5'd0, 32'd11);
    alu_vec("div_add2", OP_ADDU, 32'hFFFFFFFF, 32'd2, 32'h0, 1'b0, 5'd0, 32'd1);
    alu_vec("div_add3", OP_ADDU, 32'h12345678, 32'h11111111, 32'h0, 1'b0, 5'd0, 32'h23456789);
    idle();
    n = 3;
    while (bus.md_busy && n < 50) begin
      tick();
      n++;
    end
    check("div_busy_cycles", 64'(n), 64'(DIVC));
    read_hilo("div_alu_lo", OP_MFLO, 32'd14);
    read_hilo("div_alu_hi", OP_MFHI, 32'd2);

    // MULTU aborted by asynchronous reset
    drive(OP_MULTU, 32'd3, 32'd5, 32'h0, 1'b0, 5'd0);
    tick();
    drive(OP_ADDU, 32'h11, 32'h22, 32'h0, 1'b0, 5'd0);
    tick();
    tick();
    check("pre_rst_alu", bus.alu_out, 64'h33);
    check("pre_rst_busy", bus.md_busy, 64'd1);
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.valid_out, 64'd0);
    check("async_rst_alu", bus.alu_out, 64'd0);
    check("async_rst_we", bus.we_out, 64'd0);
    check("async_rst_wa", bus.wa_out, 64'd0);
    check("async_rst_wdata", bus.dm_wdata, 64'd0);
    check("async_rst_busy", bus.md_busy, 64'd0);
    #2;
    rst_n = 1'b1;
    read_hilo("rst_lo", OP_MFLO, 32'h0);
    read_hilo("rst_hi", OP_MFHI, 32'h0);
    idle();
    repeat (8) tick();
    read_hilo("rst_lo_late", OP_MFLO, 32'h0);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_md_stage.md
# ex_md_stage

Parametrised execute stage of the five-stage MIPS pipeline, the successor to the single-cycle EX stage: ALU datapath plus an iterative multiply/divide unit with HI/LO registers. Sits between ID/EX and EX/MEM; registers its result into the EX/MEM pipeline register. Raises a stall request to the hazard unit while a HI/LO-dependent instruction meets an in-flight multiply/divide, and inserts a bubble into MEM.

## Interface
Parameters:
- DW, 32: datapath width.
- MUL_CYCLES, 5: multiply latency in cycles, ≥1.
- DIV_CYCLES, 10: divide latency in cycles, ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- valid_in  in  1  ID/EX holds a real instruction.
- op_in  in  5  decoded operation (ex_md_pkg::op_t).
- rs_data  in  DW  forwarded rs operand.
- rt_data  in  DW  forwarded rt operand.
- imm_ext  in  DW  extended immediate.
- use_imm  in  1  ALU operand B = imm_ext, else rt_data.
- shamt  in  5  shift amount.
- wa_in  in  5  GPR write address.
- we_in  in  1  GPR write enable.
- stall_req  out  1  combinational; ID/EX and earlier must hold.
- md_busy  out  1  multiply/divide in flight.
- valid_out  out  1  EX/MEM valid.
- alu_out  out  DW  EX/MEM result.
- dm_wdata  out  DW  EX/MEM store data (rt_data).
- wa_out  out  5  EX/MEM write address.
- we_out  out  1  EX/MEM write enable, gated by valid.

## Operation
- ALU ops: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI (imm_ext << 16), wrap-around arithmetic, no overflow trap.
- MD start ops: MULT, MULTU, DIV, DIVU. Accepted when valid_in, stall_req=0: load counter with MUL_CYCLES or DIV_CYCLES, latch operands, md_busy=1. Issue to MEM as valid with we_out=0.
- Counter decrements each cycle; on the cycle counter==1, HI/LO written (MULT: {HI,LO}=product; DIV: LO=quotient, HI=remainder, signed truncating toward zero), md_busy falls next edge.
- Divide by zero: LO=all ones, HI=dividend. Signed DIV of most-negative by −1: LO=most-negative, HI=0.
- MFHI/MFLO: alu_out = HI/LO. MTHI/MTLO: write HI/LO from rs_data at the edge.
- stall_req = valid_in & md_busy & op_in ∈ {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO}. While stall_req: EX/MEM loads bubble (valid_out=0, we_out=0, alu_out=0).
- valid_in=0: bubble to EX/MEM, no state change.

## Timing
- Reset values: all outputs 0, HI=LO=0, counter=0, md_busy=0; reset mid-operation aborts the operation, no HI/LO update.
- ALU result latency 1 cycle (valid on valid_out the edge after acceptance).
- MD: start at edge T0; HI/LO valid after edge T0+N (N=MUL_CYCLES/DIV_CYCLES); MFHI presented at any time in (T0, T0+N] stalls, accepted at edge T0+N+1, result on alu_out after that edge.
- Back-to-back: MD start presented with md_busy=1 stalls; accepted on first cycle md_busy=0.
- Non-MD ALU instructions never stall, proceed while md_busy=1.
- stall_req has no registered dependency on stall_req; no combinational path from outputs to inputs.

## Structure
- Package ex_md_pkg: op_t enum, default MUL_CYCLES/DIV_CYCLES, is_md_start / is_hilo_use functions.
- Sub-module md_unit: counter, operand latches, HI/LO, md_busy; multiply/divide computed combinationally on latched operands, committed at last count. ALU and EX/MEM register in the top.

## Test plan
- Reset asserted mid-cycle with outputs nonzero -> all outputs 0 immediately, without a clock edge.
- ADDU 0x7FFFFFFF+1 -> alu_out=0x80000000 one cycle later; SLT −1 vs 1 -> 1; SRA 0x80000000 by 4 -> 0xF8000000.
- MULT −3×7 then MFLO right behind -> stall_req high for MUL_CYCLES cycles, bubbles in MEM, then alu_out=0xFFFFFFEB; MFHI -> 0xFFFFFFFF.
- DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- DIV followed by three ADDU -> no stall, ADDU results unaffected, md_busy high for DIV_CYCLES cycles.
- MULTU started, reset pulsed at cycle 2 -> md_busy=0, HI=LO=0, following MFLO returns 0 without stall.
